alu_rr_scheduler: RTL and testbench

Shares one 32-bit ALU instance between NUM_REQ requesters. The ALU instance implements ADD, SUB, AND, OR, SLL, XOR, SLT and NAND, and produces carry, zero and overflow flags. This block arbitrates round-robin among requesters, registers the winning operation, drives the ALU and captures its result and flags. It then returns the result, tagged with the requester index, over a valid/ready response channel.

---
 rtl/alu_rr_scheduler.sv | 137 +++++++++++++
 tb/tb_alu_rr_scheduler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one external ALU between NUM_REQ requesters.
// Each operation takes one issue cycle and one execute cycle, then waits in RESP until it is accepted.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         reqValid,
    output logic [NUM_REQ-1:0]         reqReady,
    input  logic [NUM_REQ*4-1:0]       reqOpcode,
    input  logic [NUM_REQ*WIDTH-1:0]   reqInput1,
    input  logic [NUM_REQ*WIDTH-1:0]   reqInput2,
    input  logic [NUM_REQ*5-1:0]       reqShift,
    output logic [3:0]                 aluOpcode,
    output logic [WIDTH-1:0]           aluInput1,
    output logic [WIDTH-1:0]           aluInput2,
    output logic [4:0]                 aluShift,
    input  logic [WIDTH-1:0]           aluResult,
    input  logic                       aluCarry,
    input  logic                       aluZero,
    input  logic                       aluOverflow,
    output logic                       rspValid,
    input  logic                       rspReady,
    output logic [ID_W-1:0]            rspId,
    output logic [WIDTH-1:0]           rspResult,
    output logic                       rspCarry,
    output logic                       rspZero,
    output logic                       rspOverflow,
    output logic                       rspIllegal,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] op_id;
    logic [ID_W-1:0] grant_id;
    logic            grant_any;
    logic            accept;
    logic [ID_W:0]   idx;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= NUM_REQ_W)
                idx = idx - NUM_REQ_W;
            if (!grant_any && reqValid[idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
    end

    assign accept = (state == IDLE) && grant_any;
    assign busy   = (state != IDLE);

    always_comb begin
        reqReady = '0;
        if (accept)
            reqReady[grant_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rspReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: reset clears the datapath too, so a reset mid-operation leaves nothing stale on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            op_id       <= '0;
            aluOpcode   <= '0;
            aluInput1   <= '0;
            aluInput2   <= '0;
            aluShift    <= '0;
            rspValid    <= 1'b0;
            rspId       <= '0;
            rspResult   <= '0;
            rspCarry    <= 1'b0;
            rspZero     <= 1'b0;
            rspOverflow <= 1'b0;
            rspIllegal  <= 1'b0;
        end else begin
            if (accept) begin
                aluOpcode <= reqOpcode[grant_id*4 +: 4];
                aluInput1 <= reqInput1[grant_id*WIDTH +: WIDTH];
                aluInput2 <= reqInput2[grant_id*WIDTH +: WIDTH];
                aluShift  <= reqShift[grant_id*5 +: 5];
                op_id     <= grant_id;
                rr_ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end
            if (state == EXEC) begin
                rspValid   <= 1'b1;
                rspId      <= op_id;
                rspIllegal <= aluOpcode[3];
                if (aluOpcode[3]) begin
                    rspResult   <= '0;
                    rspZero     <= 1'b1;
                    rspCarry    <= 1'b0;
                    rspOverflow <= 1'b0;
                end else begin
                    // Carry and overflow only mean something for ADD (0) and SUB (1).
                    rspResult   <= aluResult;
                    rspZero     <= aluZero;
                    rspCarry    <= (aluOpcode[2:1] == 2'b00) ? aluCarry    : 1'b0;
                    rspOverflow <= (aluOpcode[2:1] == 2'b00) ? aluOverflow : 1'b0;
                end
            end
            if (state == RESP && rspReady)
                rspValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: directed scenarios, then randomized traffic with backpressure.
// A behavioural ALU stub returns junk flags for non-arithmetic and illegal opcodes so masking is visible.
module tb_alu_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  res;
        logic          c;
        logic          z;
        logic          o;
        logic          ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     reqValid;
    logic [N-1:0]     reqReady;
    logic [N*4-1:0]   reqOpcode;
    logic [N*W-1:0]   reqInput1;
    logic [N*W-1:0]   reqInput2;
    logic [N*5-1:0]   reqShift;
    logic [3:0]       aluOpcode;
    logic [W-1:0]     aluInput1;
    logic [W-1:0]     aluInput2;
    logic [4:0]       aluShift;
    logic [W-1:0]     aluResult;
    logic             aluCarry;
    logic             aluZero;
    logic             aluOverflow;
    logic             rspValid;
    logic             rspReady;
    logic [IW-1:0]    rspId;
    logic [W-1:0]     rspResult;
    logic             rspCarry;
    logic             rspZero;
    logic             rspOverflow;
    logic             rspIllegal;
    logic             busy;

    logic [3:0]       op_a [N];
    logic [W-1:0]     in1_a[N];
    logic [W-1:0]     in2_a[N];
    logic [4:0]       sh_a [N];

    exp_t             sb[$];
    int               acc_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               cycle    = 0;
    int               ptr_m    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    alu_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqOpcode(reqOpcode),
        .reqInput1(reqInput1), .reqInput2(reqInput2), .reqShift(reqShift),
        .aluOpcode(aluOpcode), .aluInput1(aluInput1), .aluInput2(aluInput2), .aluShift(aluShift),
        .aluResult(aluResult), .aluCarry(aluCarry), .aluZero(aluZero), .aluOverflow(aluOverflow),
        .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId), .rspResult(rspResult),
        .rspCarry(rspCarry), .rspZero(rspZero), .rspOverflow(rspOverflow), .rspIllegal(rspIllegal),
        .busy(busy)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            reqOpcode[i*4 +: 4] = op_a[i];
            reqInput1[i*W +: W] = in1_a[i];
            reqInput2[i*W +: W] = in2_a[i];
            reqShift[i*5 +: 5]  = sh_a[i];
        end
    end

    // ALU stub: returns {carry, zero, overflow, result}; SUB carry is "no borrow".
    function automatic logic [W+2:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [4:0] sh);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         o;
        c = 1'b1;
        o = 1'b1;
        t = '0;
        case (op)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W];
                        o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd1: begin t = {1'b0, a} + {1'b0, ~b} + 1; r = t[W-1:0]; c = t[W];
                        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a << sh;
            4'd5: r = a ^ b;
            4'd6: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd7: r = ~(a & b);
            default: r = 32'hDEADBEEF;
        endcase
        z = (op < 8) ? (r == 0) : 1'b0;
        return {c, z, o, r};
    endfunction

    assign {aluCarry, aluZero, aluOverflow, aluResult} = alu_fn(aluOpcode, aluInput1, aluInput2, aluShift);

    function automatic exp_t mk(input int id, input logic [W-1:0] res, input logic c,
                                input logic z, input logic o, input logic ill);
        exp_t e;
        e.id = IW'(id); e.res = res; e.c = c; e.z = z; e.o = o; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t model_rsp(input int id, input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [4:0] sh);
        logic [W+2:0] f;
        if (op >= 8)
            return mk(id, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        f = alu_fn(op, a, b, sh);
        return mk(id, f[W-1:0], (op < 2) ? f[W+2] : 1'b0, f[W+1], (op < 2) ? f[W] : 1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Grant observer: independent round-robin model.
    always @(negedge clk) begin
        if (rst) begin
            ptr_m = 0;
            acc_q.delete();
        end else if (busy) begin
            check("ready_while_busy", reqReady, 0);
        end else begin
            int g;
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && reqValid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            if (g >= 0) begin
                check("rr_grant", reqReady, 64'(1) << g);
                acc_q.push_back(cycle);
                ptr_m = (g + 1) % N;
            end else begin
                check("ready_no_request", reqReady, 0);
            end
        end
    end

    // Response monitor: latency, stability under backpressure, scoreboard compare.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [37:0] held   = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (rspValid && !prev_v) begin
                check("rsp_expected", sb.size() != 0, 1);
                check("accept_recorded", acc_q.size() != 0, 1);
                if (acc_q.size() != 0) check("latency", cycle, acc_q.pop_front() + 2);
            end
            if (rspValid && prev_v && !prev_r)
                check("rsp_hold", {rspId, rspResult, rspCarry, rspZero, rspOverflow, rspIllegal}, held);
            if (rspValid && rspReady && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", rspId, e.id);
                check("rsp_result", rspResult, e.res);
                check("rsp_carry", rspCarry, e.c);
                check("rsp_zero", rspZero, e.z);
                check("rsp_overflow", rspOverflow, e.o);
                check("rsp_illegal", rspIllegal, e.ill);
            end
            held   = {rspId, rspResult, rspCarry, rspZero, rspOverflow, rspIllegal};
            prev_v = rspValid;
            prev_r = rspReady;
        end
    end

    task automatic set_req(input int id, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [4:0] sh);
        op_a[id] = op; in1_a[id] = a; in2_a[id] = b; sh_a[id] = sh;
        reqValid[id] = 1'b1;
    endtask

    task automatic wait_grant(input int id);
        int t;
        t = 0;
        @(negedge clk);
        while (!reqReady[id] && t < 40) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("grant_seen_%0d", id), reqReady[id], 1);
        @(posedge clk); #1;
        reqValid[id] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || rspValid) && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", sb.size(), 0);
        check("drain_rsp_idle", rspValid, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic rand_payload(input int i);
        logic [W-1:0] corners[5];
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        op_a[i]  = ($urandom_range(3) == 0) ? 4'(8 + $urandom_range(7)) : 4'($urandom_range(7));
        in1_a[i] = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : $urandom;
        in2_a[i] = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : $urandom;
        sh_a[i]  = 5'($urandom_range(31));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[6];
        int last;
        logic [N-1:0] g;
        seq = '{0, 1, 2, 3, 0, 1};
        reqValid = '0;
        rspReady = 1'b1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; in1_a[i] = '0; in2_a[i] = '0; sh_a[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single ADD with carry out and zero result.
        @(posedge clk); #1;
        sb.push_back(mk(0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0));
        set_req(0, 4'd0, 32'hFFFFFFFF, 32'h1, 5'd0);
        wait_grant(0);
        drain();

        // Reset after activity must clear everything.
        do_reset();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rspValid, 0);
        check("rst_alu_opcode", aluOpcode, 0);
        check("rst_alu_in1", aluInput1, 0);
        check("rst_alu_in2", aluInput2, 0);
        check("rst_alu_shift", aluShift, 0);
        check("rst_rsp_fields", {rspId, rspResult, rspCarry, rspZero, rspOverflow, rspIllegal}, 0);

        // Signed overflow on SUB.
        @(posedge clk); #1;
        sb.push_back(mk(2, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0));
        set_req(2, 4'd1, 32'h80000000, 32'h1, 5'd0);
        wait_grant(2);
        drain();

        // Round-robin fairness with all requesters valid.
        do_reset();
        for (int k = 0; k < 6; k++)
            sb.push_back(mk(seq[k], 32'(100 + seq[k]), 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < N; i++) set_req(i, 4'd0, 32'(i), 32'd100, 5'd0);
        last = 0;
        for (int k = 0; k < 6; k++) begin
            int t;
            int idx;
            t = 0;
            @(negedge clk);
            while (reqReady == 0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            idx = -1;
            for (int i = 0; i < N; i++) if (reqReady[i]) idx = i;
            check("fair_order", idx, seq[k]);
            if (k > 0) check("fair_spacing", cycle - last, 3);
            last = cycle;
        end
        @(posedge clk); #1;
        reqValid = '0;
        drain();

        // Backpressure: response held while another requester waits.
        @(posedge clk); #1;
        rspReady = 1'b0;
        sb.push_back(mk(1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk(3, 32'h6, 1'b0, 1'b0, 1'b0, 1'b0));
        set_req(1, 4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        wait_grant(1);
        set_req(3, 4'd5, 32'h5, 32'h3, 5'd0);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!rspValid && t < 10) begin
                @(negedge clk);
                t++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", rspValid, 1);
            check("bp_busy", busy, 1);
            check("bp_ready_low", reqReady, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rspReady = 1'b1;
        @(negedge clk);
        check("bp_still_resp", busy, 1);
        wait_grant(3);
        drain();

        // Illegal opcode, then SLL whose junk ALU flags must be masked.
        @(posedge clk); #1;
        sb.push_back(mk(0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
        set_req(0, 4'd9, 32'h123, 32'h456, 5'd7);
        wait_grant(0);
        drain();
        @(posedge clk); #1;
        sb.push_back(mk(1, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0));
        set_req(1, 4'd4, 32'h1, 32'h0, 5'd31);
        wait_grant(1);
        drain();

        // Reset while the operation is in EXEC: nothing may come out.
        do_reset();
        @(posedge clk); #1;
        set_req(1, 4'd0, 32'd10, 32'd20, 5'd0);
        wait_grant(1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_exec_no_rsp", rspValid, 0);
            check("rst_exec_busy", busy, 0);
        end
        @(posedge clk); #1;
        sb.push_back(mk(0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk(3, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0));
        set_req(0, 4'd0, 32'd1, 32'd2, 5'd0);
        set_req(3, 4'd0, 32'd3, 32'd4, 5'd0);
        @(negedge clk);
        check("restart_from_0", reqReady, 4'b0001);
        @(posedge clk); #1;
        reqValid[0] = 1'b0;
        wait_grant(3);
        drain();

        // Randomized traffic with random backpressure and dropped requests.
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            g = reqReady & reqValid;
            for (int i = 0; i < N; i++)
                if (g[i]) sb.push_back(model_rsp(i, op_a[i], in1_a[i], in2_a[i], sh_a[i]));
            @(posedge clk); #1;
            rspReady = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                if (g[i] || !reqValid[i]) begin
                    if ($urandom_range(1) == 1) begin
                        rand_payload(i);
                        reqValid[i] = 1'b1;
                    end else begin
                        reqValid[i] = 1'b0;
                    end
                end else if ($urandom_range(15) == 0) begin
                    reqValid[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        g = reqReady & reqValid;
        for (int i = 0; i < N; i++)
            if (g[i]) sb.push_back(model_rsp(i, op_a[i], in1_a[i], in2_a[i], sh_a[i]));
        @(posedge clk); #1;
        reqValid = '0;
        rspReady = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
